coin_start_sequencer: RTL and testbench

// Conditions the merged start/coin requests (joystick + keyboard) in the emu top and drives the

---
 rtl/coin_start_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_coin_start_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/coin_start_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coin_start_sequencer: turns debounced start/coin requests into timed        |
// | coin1/start1/start2 pulses for the game core.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module coin_start_sequencer #(
  parameter int TICK_DIV  = 12000,
  parameter int DEB_U     = 10,
  parameter int COIN_U    = 50,
  parameter int GAP_U     = 100,
  parameter int START_U   = 50,
  parameter int AUTO_COIN = 1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic in_start1,
  input  logic in_start2,
  input  logic in_coin,
  output logic coin1,
  output logic start1,
  output logic start2,
  output logic busy
);

  localparam int D_CYC   = DEB_U   * TICK_DIV;
  localparam int C_CYC   = COIN_U  * TICK_DIV;
  localparam int G_CYC   = GAP_U   * TICK_DIV;
  localparam int S_CYC   = START_U * TICK_DIV;
  localparam int MAX_CG  = (C_CYC > G_CYC) ? C_CYC : G_CYC;
  localparam int MAX_SD  = (S_CYC > D_CYC) ? S_CYC : D_CYC;
  localparam int MAX_ALL = (MAX_CG > MAX_SD) ? MAX_CG : MAX_SD;
  localparam int TW      = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);

  localparam logic [TW-1:0] D_LAST = TW'(D_CYC - 1);
  localparam logic [TW-1:0] C_LAST = TW'(C_CYC - 1);
  localparam logic [TW-1:0] G_LAST = TW'(G_CYC - 1);
  localparam logic [TW-1:0] S_LAST = TW'(S_CYC - 1);
  localparam logic [TW-1:0] ONE    = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COIN  = 3'd1,
    S_GAP   = 3'd2,
    S_START = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // Bit order everywhere: [0]=start1, [1]=start2, [2]=coin (also the priority order).
  logic [2:0] w_raw;
  logic [2:0] w_ev;
  assign w_raw = {in_coin, in_start2, in_start1};

  for (genvar i = 0; i < 3; i++) begin : g_cond
    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic          r_deb_q;
    logic          r_ev;
    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_deb   <= 1'b0;
        r_deb_q <= 1'b0;
        r_ev    <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_s1    <= w_raw[i];
        r_s2    <= r_s1;
        r_deb_q <= r_deb;
        r_ev    <= r_deb & ~r_deb_q;
        // Count consecutive disagreeing samples; any agreeing sample restarts it.
        if (r_s2 != r_deb) begin
          if (r_cnt == D_LAST) begin
            r_deb <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_ev[i] = r_ev;
  end

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_sel;
  logic [2:0]    r_pend;
  logic [2:0]    w_req;
  logic [2:0]    w_rest;
  logic [1:0]    w_pick;

  // Arbitration among pending and fresh requests; w_pick 1/2 = player, 3 = coin only.
  always_comb begin
    w_req  = r_pend | w_ev;
    w_rest = w_req;
    w_pick = 2'd0;
    if (w_req[0]) begin
      w_pick    = 2'd1;
      w_rest[0] = 1'b0;
    end else if (w_req[1]) begin
      w_pick    = 2'd2;
      w_rest[1] = 1'b0;
    end else if (w_req[2]) begin
      w_pick    = 2'd3;
      w_rest[2] = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_sel   <= 2'd0;
      r_pend  <= 3'b000;
      coin1   <= 1'b0;
      start1  <= 1'b0;
      start2  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pend <= w_rest;
          if (w_pick == 2'd3 || (w_pick != 2'd0 && AUTO_COIN != 0)) begin
            r_state <= S_COIN;
            r_timer <= C_LAST;
            r_sel   <= (w_pick == 2'd3) ? 2'd0 : w_pick;
            coin1   <= 1'b1;
            busy    <= 1'b1;
          end else if (w_pick != 2'd0) begin
            r_state <= S_START;
            r_timer <= S_LAST;
            r_sel   <= w_pick;
            start1  <= (w_pick == 2'd1);
            start2  <= (w_pick == 2'd2);
            busy    <= 1'b1;
          end
        end
        S_COIN: begin
          r_pend <= r_pend | w_ev;
          if (r_timer == '0) begin
            r_state <= S_GAP;
            r_timer <= G_LAST;
            coin1   <= 1'b0;
          end else begin
            r_timer <= r_timer - ONE;
          end
        end
        S_GAP: begin
          r_pend <= r_pend | w_ev;
          if (r_timer == '0) begin
            if (r_sel != 2'd0) begin
              r_state <= S_START;
              r_timer <= S_LAST;
              start1  <= (r_sel == 2'd1);
              start2  <= (r_sel == 2'd2);
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_timer <= r_timer - ONE;
          end
        end
        S_START: begin
          r_pend <= r_pend | w_ev;
          if (r_timer == '0) begin
            r_state <= S_HOLD;
            r_timer <= G_LAST;
            start1  <= 1'b0;
            start2  <= 1'b0;
          end else begin
            r_timer <= r_timer - ONE;
          end
        end
        S_HOLD: begin
          r_pend <= r_pend | w_ev;
          if (r_timer == '0) begin
            r_state <= S_IDLE;
            r_sel   <= 2'd0;
            busy    <= 1'b0;
          end else begin
            r_timer <= r_timer - ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
          r_sel   <= 2'd0;
          coin1   <= 1'b0;
          start1  <= 1'b0;
          start2  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coin_start_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_coin_start_sequencer: drives both AUTO_COIN variants with shared inputs  |
// | and compares every cycle against a schedule-level reference model.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_coin_start_sequencer;

  localparam int TD = 4, DU = 2, CU = 3, GU = 2, SU = 3;
  localparam int D = TD * DU;
  localparam int C = TD * CU;
  localparam int G = TD * GU;
  localparam int S = TD * SU;
  localparam int MAXN = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_start1 = 1'b0, in_start2 = 1'b0, in_coin = 1'b0;
  logic a_coin1, a_start1, a_start2, a_busy;
  logic b_coin1, b_start1, b_start2, b_busy;

  always #5 clk = ~clk;

  coin_start_sequencer #(.TICK_DIV(TD), .DEB_U(DU), .COIN_U(CU), .GAP_U(GU),
                         .START_U(SU), .AUTO_COIN(1)) dut_auto (
    .clk_sys(clk), .reset(reset), .in_start1(in_start1), .in_start2(in_start2),
    .in_coin(in_coin), .coin1(a_coin1), .start1(a_start1), .start2(a_start2), .busy(a_busy));

  coin_start_sequencer #(.TICK_DIV(TD), .DEB_U(DU), .COIN_U(CU), .GAP_U(GU),
                         .START_U(SU), .AUTO_COIN(0)) dut_noauto (
    .clk_sys(clk), .reset(reset), .in_start1(in_start1), .in_start2(in_start2),
    .in_coin(in_coin), .coin1(b_coin1), .start1(b_start1), .start2(b_start2), .busy(b_busy));

  // Index 0 = start1, 1 = start2, 2 = coin. Output vector = {coin1,start1,start2,busy}.
  bit         st [3][MAXN];
  bit         ev [3][MAXN];
  logic [3:0] exp_a [MAXN];
  logic [3:0] exp_b [MAXN];
  int vectors = 0;
  int miscompares = 0;

  task automatic clear_stim();
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < MAXN; k++) st[t][k] = 1'b0;
  endtask

  task automatic hold(input int t, input int from, input int to);
    for (int k = from; k <= to && k < MAXN; k++) st[t][k] = 1'b1;
  endtask

  task automatic rand_stim(input int n);
    for (int t = 0; t < 3; t++) begin
      int k = 0;
      while (k < n) begin
        int len = $urandom_range(1, 30);
        bit v = ($urandom_range(0, 99) < ((t == 2) ? 35 : 20));
        for (int j = 0; j < len && k < n; j++) begin
          st[t][k] = v;
          k++;
        end
      end
    end
  endtask

  task automatic set_bits(input bit auto_c, input int from, input int len, input logic [3:0] mask);
    for (int i = from; i < from + len && i < MAXN; i++) begin
      if (auto_c) exp_a[i] = exp_a[i] | mask;
      else        exp_b[i] = exp_b[i] | mask;
    end
  endtask

  // Schedule model: a request accepted at edge s occupies a fixed-length window;
  // the next decision edge is one idle cycle after the window closes.
  task automatic model_one(input bit auto_c);
    bit pend [3];
    int ready = 0;
    for (int t = 0; t < 3; t++) pend[t] = 1'b0;
    for (int e = 0; e < MAXN; e++) begin
      int pick = -1;
      for (int t = 0; t < 3; t++) if (ev[t][e]) pend[t] = 1'b1;
      if (e >= ready) begin
        if (pend[0]) pick = 0;
        else if (pend[1]) pick = 1;
        else if (pend[2]) pick = 2;
      end
      if (pick >= 0) begin
        logic [3:0] smask = (pick == 0) ? 4'b0100 : 4'b0010;
        int len;
        pend[pick] = 1'b0;
        if (pick == 2) begin
          len = C + G;
          set_bits(auto_c, e, C, 4'b1000);
        end else if (auto_c) begin
          len = C + G + S + G;
          set_bits(auto_c, e, C, 4'b1000);
          set_bits(auto_c, e + C + G, S, smask);
        end else begin
          len = S + G;
          set_bits(auto_c, e, S, smask);
        end
        set_bits(auto_c, e, len, 4'b0001);
        ready = e + len + 1;
      end
    end
  endtask

  task automatic build_model(input int n);
    for (int t = 0; t < 3; t++) begin
      int level = 0, runval = 0, runlen = 0;
      for (int k = 0; k < MAXN; k++) ev[t][k] = 1'b0;
      // A level counts once it has been stable for D samples; rising level = event.
      for (int j = 0; j < n; j++) begin
        if (int'(st[t][j]) == runval) runlen++;
        else begin
          runval = int'(st[t][j]);
          runlen = 1;
        end
        if (runval != level && runlen >= D) begin
          level = runval;
          if (level == 1 && j + 4 < MAXN) ev[t][j + 4] = 1'b1;
        end
      end
    end
    for (int k = 0; k < MAXN; k++) begin
      exp_a[k] = 4'b0000;
      exp_b[k] = 4'b0000;
    end
    model_one(1'b1);
    model_one(1'b0);
  endtask

  task automatic check(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s cyc %0d observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  task automatic run(input string tag, input int n, input int rst_at);
    build_model(n);
    reset = 1'b1;
    in_start1 = st[0][0];
    in_start2 = st[1][0];
    in_coin   = st[2][0];
    @(posedge clk); #1;
    check({tag, "_rst_a"}, -1, {a_coin1, a_start1, a_start2, a_busy}, 4'b0000);
    check({tag, "_rst_b"}, -1, {b_coin1, b_start1, b_start2, b_busy}, 4'b0000);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_start1 = st[0][k];
      in_start2 = st[1][k];
      in_coin   = st[2][k];
      @(posedge clk); #1;
      check({tag, "_a"}, k, {a_coin1, a_start1, a_start2, a_busy}, exp_a[k]);
      check({tag, "_b"}, k, {b_coin1, b_start1, b_start2, b_busy}, exp_b[k]);
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        check({tag, "_async_a"}, k, {a_coin1, a_start1, a_start2, a_busy}, 4'b0000);
        check({tag, "_async_b"}, k, {b_coin1, b_start1, b_start2, b_busy}, 4'b0000);
        break;
      end
    end
  endtask

  initial begin
    // Held start1: coin 11..22, start1 31..42, busy 11..50 (auto variant)
    clear_stim();
    hold(0, 0, 79);
    run("s1_start1", 80, -1);

    // Short coin glitch ignored; long coin gives a lone coin pulse
    clear_stim();
    hold(2, 2, 6);
    hold(2, 30, 49);
    run("s2_coin", 100, -1);

    // Simultaneous start1/start2: start1 first, start2 after one idle cycle
    clear_stim();
    hold(0, 0, 139);
    hold(1, 0, 139);
    run("s3_both", 140, -1);

    // Two coin events while busy collapse into one extra coin
    clear_stim();
    hold(0, 0, 109);
    hold(2, 20, 34);
    hold(2, 40, 54);
    run("s4_pend", 110, -1);

    // Async reset mid-START, then a fresh sequence from the still-held input
    clear_stim();
    hold(0, 0, 99);
    run("s5_midrst", 60, 35);
    run("s5_after", 80, -1);

    // Held start2 (no-auto variant: start2 11..22, no coin)
    clear_stim();
    hold(1, 0, 59);
    run("s6_start2", 60, -1);

    for (int r = 0; r < 6; r++) begin
      clear_stim();
      rand_stim(300);
      run("rand", 300, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
